reg_arbiter: RTL and testbench

//  Shares one reg_ifc slave (AWIDTH/DWIDTH register port) between NPORTS requesters.
//  One transaction slot per cycle on the slave side; grant is round-robin (or fixed priority).

---
 rtl/reg_arbiter.sv | 142 ++++++++++++++
 tb/tb_reg_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_arbiter.sv
// Shares one register-port slave between NPORTS requesters, one slave slot per cycle.
// Round-robin grant by default; define REG_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module reg_arbiter #(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned AWIDTH = 2,
  parameter int unsigned DWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NPORTS-1:0]        m_rd,
  input  logic [NPORTS-1:0]        m_wr,
  input  logic [NPORTS*AWIDTH-1:0] m_raddr,
  input  logic [NPORTS*AWIDTH-1:0] m_waddr,
  input  logic [NPORTS*DWIDTH-1:0] m_wdata,
  output logic [NPORTS-1:0]        m_ack,
  output logic [NPORTS-1:0]        m_rvalid,
  output logic [DWIDTH-1:0]        m_rdata,
  output logic                     s_rd,
  output logic                     s_wr,
  output logic [AWIDTH-1:0]        s_raddr,
  output logic [AWIDTH-1:0]        s_waddr,
  output logic [DWIDTH-1:0]        s_wdata,
  input  logic [DWIDTH-1:0]        s_rdata
);

  localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [NPORTS-1:0] req;
  logic              gnt_vld;
  logic [PW-1:0]     gnt_idx;

  logic              s_rd_q, s_rd_d;
  logic              s_wr_q, s_wr_d;
  logic [AWIDTH-1:0] s_raddr_q, s_raddr_d;
  logic [AWIDTH-1:0] s_waddr_q, s_waddr_d;
  logic [DWIDTH-1:0] s_wdata_q, s_wdata_d;
  logic [NPORTS-1:0] m_ack_q, m_ack_d;
  logic [NPORTS-1:0] m_rvalid_q, m_rvalid_d;

  // A port acked this cycle is masked so its still-held request is not issued twice.
  always_comb begin
    req = (m_rd | m_wr) & ~m_ack_q;
  end

`ifdef REG_ARB_FIXED_PRIO_EN
  // Descending scan: the lowest requesting index is written last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] ptr_q, ptr_d;
  int unsigned   rr_idx;

  // Descending offset scan from the pointer: the smallest offset wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    for (int off = NPORTS - 1; off >= 0; off--) begin
      rr_idx = int'(ptr_q) + off;
      if (rr_idx >= NPORTS) begin
        rr_idx = rr_idx - NPORTS;
      end
      if (req[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(rr_idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == PW'(NPORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    s_rd_d     = 1'b0;
    s_wr_d     = 1'b0;
    s_raddr_d  = s_raddr_q;
    s_waddr_d  = s_waddr_q;
    s_wdata_d  = s_wdata_q;
    m_ack_d    = '0;
    if (gnt_vld) begin
      s_rd_d            = m_rd[gnt_idx];
      s_wr_d            = m_wr[gnt_idx];
      s_raddr_d         = m_raddr[gnt_idx*AWIDTH +: AWIDTH];
      s_waddr_d         = m_waddr[gnt_idx*AWIDTH +: AWIDTH];
      s_wdata_d         = m_wdata[gnt_idx*DWIDTH +: DWIDTH];
      m_ack_d[gnt_idx]  = 1'b1;
    end
    // Read data arrives one cycle after s_rd; tag it with the port that issued it.
    m_rvalid_d = s_rd_q ? m_ack_q : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_rd_q     <= 1'b0;
      s_wr_q     <= 1'b0;
      s_raddr_q  <= '0;
      s_waddr_q  <= '0;
      s_wdata_q  <= '0;
      m_ack_q    <= '0;
      m_rvalid_q <= '0;
    end else begin
      s_rd_q     <= s_rd_d;
      s_wr_q     <= s_wr_d;
      s_raddr_q  <= s_raddr_d;
      s_waddr_q  <= s_waddr_d;
      s_wdata_q  <= s_wdata_d;
      m_ack_q    <= m_ack_d;
      m_rvalid_q <= m_rvalid_d;
    end
  end

  assign s_rd     = s_rd_q;
  assign s_wr     = s_wr_q;
  assign s_raddr  = s_raddr_q;
  assign s_waddr  = s_waddr_q;
  assign s_wdata  = s_wdata_q;
  assign m_ack    = m_ack_q;
  assign m_rvalid = m_rvalid_q;
  assign m_rdata  = s_rdata;

endmodule

// File: tb/tb_reg_arbiter.sv
// Scoreboard bench for reg_arbiter (4 ports) with a small register-bank slave model.
module tb_reg_arbiter;

  localparam int NP = 4;
  localparam int AW = 2;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NP-1:0]    m_rd = '0;
  logic [NP-1:0]    m_wr = '0;
  logic [NP*AW-1:0] m_raddr = '0;
  logic [NP*AW-1:0] m_waddr = '0;
  logic [NP*DW-1:0] m_wdata = '0;
  logic [NP-1:0]    m_ack;
  logic [NP-1:0]    m_rvalid;
  logic [DW-1:0]    m_rdata;
  logic             s_rd, s_wr;
  logic [AW-1:0]    s_raddr, s_waddr;
  logic [DW-1:0]    s_wdata;
  logic [DW-1:0]    s_rdata;

  reg_arbiter #(.NPORTS(NP), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_rd(m_rd), .m_wr(m_wr), .m_raddr(m_raddr), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .s_rd(s_rd), .s_wr(s_wr), .s_raddr(s_raddr), .s_waddr(s_waddr), .s_wdata(s_wdata),
    .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  // Slave register bank: read data registered, valid the cycle after s_rd.
  logic [DW-1:0] mem [4];
  always @(posedge clk) begin
    if (s_rd) s_rdata <= mem[s_raddr];
    if (s_wr) mem[s_waddr] <= s_wdata;
  end

  typedef struct {
    int            port;
    logic          rd;
    logic          wr;
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } ack_t;
  typedef struct {
    int            port;
    logic [DW-1:0] d;
  } rv_t;

  ack_t ack_q[$];
  rv_t  rv_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an ack or read-valid.
  always @(negedge clk) begin
    ack_t          ea;
    rv_t           er;
    logic [NP-1:0] oh;
    if (m_ack != '0) begin
      check("ack_onehot", 64'($countones(m_ack)), 64'd1);
      if (ack_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected actual=%b required=none", m_ack);
      end else begin
        ea = ack_q.pop_front();
        oh = '0;
        oh[ea.port] = 1'b1;
        check("ack_port", 64'(m_ack), 64'(oh));
        check("s_rd", 64'(s_rd), 64'(ea.rd));
        check("s_wr", 64'(s_wr), 64'(ea.wr));
        check("s_raddr", 64'(s_raddr), 64'(ea.ra));
        check("s_waddr", 64'(s_waddr), 64'(ea.wa));
        check("s_wdata", 64'(s_wdata), 64'(ea.wd));
      end
    end else begin
      check("idle_no_cmd", 64'({s_rd, s_wr}), 64'd0);
    end
    if (m_rvalid != '0) begin
      check("rvalid_onehot", 64'($countones(m_rvalid)), 64'd1);
      if (rv_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected actual=%b required=none", m_rvalid);
      end else begin
        er = rv_q.pop_front();
        oh = '0;
        oh[er.port] = 1'b1;
        check("rvalid_port", 64'(m_rvalid), 64'(oh));
        check("m_rdata", 64'(m_rdata), 64'(er.d));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic rd, input logic wr, input logic [AW-1:0] ra,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    m_rd[p] = rd;
    m_wr[p] = wr;
    m_raddr[p*AW +: AW] = ra;
    m_waddr[p*AW +: AW] = wa;
    m_wdata[p*DW +: DW] = wd;
  endtask

  task automatic expect_ack(input int p, input logic rd, input logic wr, input logic [AW-1:0] ra,
                            input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    ack_t e;
    e.port = p; e.rd = rd; e.wr = wr; e.ra = ra; e.wa = wa; e.wd = wd;
    ack_q.push_back(e);
  endtask

  task automatic expect_rv(input int p, input logic [DW-1:0] d);
    rv_t e;
    e.port = p; e.d = d;
    rv_q.push_back(e);
  endtask

  // Single isolated transaction: raise, drop during the ack cycle, then idle.
  task automatic txn(input int p, input logic rd, input logic wr, input logic [AW-1:0] ra,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [DW-1:0] rexp);
    drive(p, rd, wr, ra, wa, wd);
    expect_ack(p, rd, wr, ra, wa, wd);
    if (rd) expect_rv(p, rexp);
    step();
    drive(p, 1'b0, 1'b0, ra, wa, wd);
    repeat (3) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_ack"}, 64'(m_ack), 64'd0);
    check({tag, "_m_rvalid"}, 64'(m_rvalid), 64'd0);
    check({tag, "_s_rd"}, 64'(s_rd), 64'd0);
    check({tag, "_s_wr"}, 64'(s_wr), 64'd0);
    check({tag, "_s_raddr"}, 64'(s_raddr), 64'd0);
    check({tag, "_s_waddr"}, 64'(s_waddr), 64'd0);
    check({tag, "_s_wdata"}, 64'(s_wdata), 64'd0);
  endtask

  logic [DW-1:0] bank [4];
  int            order [8];

  initial begin
    bank[0] = 32'hCAFEF00D;
    bank[1] = 32'hDEADBEEF;
    bank[2] = 32'h12345678;
    bank[3] = 32'h0BADC0DE;
`ifdef REG_ARB_FIXED_PRIO_EN
    order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    reset_n = 1'b1;
    repeat (2) step();

    // Single write from port 0, then fill the bank.
    txn(0, 1'b0, 1'b1, 2'd0, 2'd1, 32'hDEADBEEF, 32'h0);
    txn(2, 1'b0, 1'b1, 2'd0, 2'd2, 32'h12345678, 32'h0);
    txn(1, 1'b0, 1'b1, 2'd0, 2'd3, 32'h0BADC0DE, 32'h0);
    // Port 1 reads back register 2.
    txn(1, 1'b1, 1'b0, 2'd2, 2'd0, 32'h0, 32'h12345678);
    // Port 3 last winner leaves the round-robin pointer at 0.
    txn(3, 1'b0, 1'b1, 2'd0, 2'd0, 32'hCAFEF00D, 32'h0);

    // All four ports hold reads for eight cycles.
    for (int i = 0; i < NP; i++) drive(i, 1'b1, 1'b0, AW'(i), 2'd0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      expect_ack(order[k], 1'b1, 1'b0, AW'(order[k]), 2'd0, 32'h0);
      expect_rv(order[k], bank[order[k]]);
    end
    repeat (8) step();
    for (int i = 0; i < NP; i++) drive(i, 1'b0, 1'b0, AW'(i), 2'd0, 32'h0);
    repeat (4) step();

    // Same port read and write together: one slot, read sees the old value.
    txn(0, 1'b1, 1'b1, 2'd0, 2'd3, 32'h55AA55AA, 32'hCAFEF00D);

    // Reset during the ack cycle of a read: nothing may come back.
    drive(1, 1'b1, 1'b0, 2'd3, 2'd0, 32'h0);
    step();
    reset_n = 1'b0;
    drive(1, 1'b0, 1'b0, 2'd3, 2'd0, 32'h0);
    @(negedge clk);
    check_reset_outputs("midreset");
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();

    // Ports 0 and 2 together: port 0 first, port 2 on the next cycle.
    drive(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h11111111);
    drive(2, 1'b1, 1'b0, 2'd1, 2'd0, 32'h0);
    expect_ack(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h11111111);
    expect_ack(2, 1'b1, 1'b0, 2'd1, 2'd0, 32'h0);
    expect_rv(2, 32'hDEADBEEF);
    step();
    drive(0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
    step();
    drive(2, 1'b0, 1'b0, 2'd1, 2'd0, 32'h0);
    repeat (4) step();

    check("ack_queue_drained", 64'(ack_q.size()), 64'd0);
    check("rvalid_queue_drained", 64'(rv_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
